// File: rtl/key_pkg.sv
// Shared key-code definitions for the keypad front-end and the door-lock FSM.
package key_pkg;

  localparam int KEY_CODE_W = 4;
  typedef logic [KEY_CODE_W-1:0] key_code_t;

  localparam key_code_t SN = 4'd0;
  localparam key_code_t SA = 4'd1;
  localparam key_code_t SS = 4'd2;
  localparam key_code_t S0 = 4'd3;
  localparam key_code_t S1 = 4'd4;
  localparam key_code_t S2 = 4'd5;
  localparam key_code_t S3 = 4'd6;
  localparam key_code_t S4 = 4'd7;
  localparam key_code_t S5 = 4'd8;
  localparam key_code_t S6 = 4'd9;
  localparam key_code_t S7 = 4'd10;
  localparam key_code_t S8 = 4'd11;
  localparam key_code_t S9 = 4'd12;

  typedef enum logic [1:0] {
    IDLE,
    CONFIRM_PRESS,
    HELD,
    CONFIRM_RELEASE
  } deb_state_e;

  // Rows 0..2 carry digits 1..9 laid out row-major; row 3 is '*', '0', '#'.
  function automatic key_code_t key_map(input logic [1:0] row, input logic [1:0] col);
    key_code_t code;
    code = SN;
    if (row == 2'd3) begin
      case (col)
        2'd0:    code = SA;
        2'd1:    code = S0;
        2'd2:    code = SS;
        default: code = SN;
      endcase
    end else begin
      code = S1 + key_code_t'({row, 1'b0}) + key_code_t'(row) + key_code_t'(col);
    end
    return code;
  endfunction

endpackage

// File: rtl/key_scan_frame.sv
// Column driver and per-frame key code generation for the 3x4 keypad.
// KEY_GHOST_REJECT_EN: frames with more than one pressed key report SN.
module key_scan_frame
  import key_pkg::*;
#(
  parameter int SCAN_DIV = 1
) (
  input  logic            slow_clk,
  input  logic            reset,
  input  logic [3:0]      key_row,
  output logic [2:0]      key_col,
  output logic            frame_valid,
  output key_code_t       frame_code
);

  localparam int DW_W = (SCAN_DIV < 2) ? 1 : $clog2(SCAN_DIV);

  logic [1:0]        col_idx_q, col_idx_d;
  logic [DW_W-1:0]   dwell_q, dwell_d;
  logic [2:0][3:0]   hits_q, hits_d, hits_now;
  logic              sample;
  logic [3:0]        n_hits;
  logic              found;
  key_code_t         first_code;

  always_comb begin
    sample    = (dwell_q == DW_W'(SCAN_DIV - 1));
    dwell_d   = sample ? '0 : dwell_q + DW_W'(1);
    col_idx_d = col_idx_q;
    if (sample) col_idx_d = (col_idx_q == 2'd2) ? 2'd0 : col_idx_q + 2'd1;

    // Column 0 opens a fresh frame so stale hits never leak across frames.
    hits_now = hits_q;
    case (col_idx_q)
      2'd0: begin
        hits_now    = '0;
        hits_now[0] = key_row;
      end
      2'd1:    hits_now[1] = key_row;
      2'd2:    hits_now[2] = key_row;
      default: hits_now    = hits_q;
    endcase
    hits_d      = sample ? hits_now : hits_q;
    frame_valid = sample && (col_idx_q == 2'd2);
  end

  always_comb begin
    n_hits     = '0;
    found      = 1'b0;
    first_code = SN;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (hits_now[c][r]) begin
          if (!found) first_code = key_map(2'(r), 2'(c));
          found  = 1'b1;
          n_hits = n_hits + 4'd1;
        end
      end
    end
    frame_code = first_code;
`ifdef KEY_GHOST_REJECT_EN
    if (n_hits > 4'd1) frame_code = SN;
`else
    if (n_hits == 4'd0) frame_code = SN;
`endif
  end

  always_ff @(posedge slow_clk) begin
    if (reset) begin
      col_idx_q <= '0;
      dwell_q   <= '0;
      hits_q    <= '0;
    end else begin
      col_idx_q <= col_idx_d;
      dwell_q   <= dwell_d;
      hits_q    <= hits_d;
    end
  end

  assign key_col = 3'b001 << col_idx_q;

endmodule

// File: rtl/key_scan_debounce.sv
// Keypad scanner plus frame-level debounce; num always returns to SN between keys.
// KEY_GHOST_REJECT_EN (see key_scan_frame) turns multi-key frames into SN.
//   state           | meaning
//   IDLE            | no key accepted, waiting for a non-SN frame
//   CONFIRM_PRESS   | counting identical frames of the candidate key
//   HELD            | num carries the accepted key
//   CONFIRM_RELEASE | counting frames that differ from num
module key_scan_debounce
  import key_pkg::*;
#(
  parameter int SCAN_DIV = 1,
  parameter int DEBOUNCE = 4
) (
  input  logic                  slow_clk,
  input  logic                  reset,
  input  logic [3:0]            key_row,
  output logic [2:0]            key_col,
  output logic [KEY_CODE_W-1:0] num,
  output logic                  key_press
);

  localparam int CNT_W = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE);

  logic        frame_valid;
  key_code_t   frame_code;

  deb_state_e       state_q, state_d;
  key_code_t        cand_q, cand_d;
  key_code_t        num_q, num_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             key_press_q, key_press_d;

  key_scan_frame #(.SCAN_DIV(SCAN_DIV)) u_frame (
    .slow_clk    (slow_clk),
    .reset       (reset),
    .key_row     (key_row),
    .key_col     (key_col),
    .frame_valid (frame_valid),
    .frame_code  (frame_code)
  );

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    num_d       = num_q;
    cnt_d       = cnt_q;
    key_press_d = 1'b0;
    cnt_inc     = cnt_q + CNT_W'(1);

    if (frame_valid) begin
      case (state_q)
        IDLE: begin
          if (frame_code != SN) begin
            if (DEBOUNCE == 1) begin
              num_d       = frame_code;
              key_press_d = 1'b1;
              cnt_d       = CNT_TC;
              state_d     = HELD;
            end else begin
              cand_d  = frame_code;
              cnt_d   = CNT_W'(1);
              state_d = CONFIRM_PRESS;
            end
          end
        end
        CONFIRM_PRESS: begin
          if (frame_code == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_TC) begin
              num_d       = cand_q;
              key_press_d = 1'b1;
              state_d     = HELD;
            end
          end else if (frame_code == SN) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cand_d = frame_code;
            cnt_d  = CNT_W'(1);
          end
        end
        HELD: begin
          if (frame_code != num_q) begin
            if (DEBOUNCE == 1) begin
              num_d   = SN;
              cnt_d   = '0;
              state_d = IDLE;
            end else begin
              cnt_d   = CNT_W'(1);
              state_d = CONFIRM_RELEASE;
            end
          end
        end
        CONFIRM_RELEASE: begin
          if (frame_code != num_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_TC) begin
              num_d   = SN;
              cnt_d   = '0;
              state_d = IDLE;
            end
          end else begin
            state_d = HELD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge slow_clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cand_q      <= SN;
      num_q       <= SN;
      cnt_q       <= '0;
      key_press_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      num_q       <= num_d;
      cnt_q       <= cnt_d;
      key_press_q <= key_press_d;
    end
  end

  assign num       = num_q;
  assign key_press = key_press_q;

endmodule

// File: tb/tb_key_scan_debounce.sv
// Directed and randomized bench for key_scan_debounce with a frame-level reference model.
module tb_key_scan_debounce;

  logic       slow_clk = 1'b0;
  logic       reset    = 1'b1;
  logic [3:0] key_row;
  logic [2:0] key_col;
  logic [3:0] num;
  logic       key_press;

  // pressed[r*3+c] = key at row r, column c is held down
  logic [11:0] pressed = '0;

  localparam int DEB = 4;

  always #5 slow_clk = ~slow_clk;

  assign key_row[0] = |(pressed[2:0]  & key_col);
  assign key_row[1] = |(pressed[5:3]  & key_col);
  assign key_row[2] = |(pressed[8:6]  & key_col);
  assign key_row[3] = |(pressed[11:9] & key_col);

  key_scan_debounce dut (
    .slow_clk  (slow_clk),
    .reset     (reset),
    .key_row   (key_row),
    .key_col   (key_col),
    .num       (num),
    .key_press (key_press)
  );

  int checks = 0;
  int passed = 0;
  int pulses = 0;
  int m_num  = 0;
  int m_cand = 0;
  int m_run  = 0;
  // lock code of each key, indexed row-major: 1..9, *, 0, #
  int code_tab [12] = '{4, 5, 6, 7, 8, 9, 10, 11, 12, 1, 3, 2};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic int frame_code(input logic [11:0] k);
    int n;
    n = $countones(k);
    if (n == 0) return 0;
`ifdef KEY_GHOST_REJECT_EN
    if (n > 1) return 0;
`endif
    for (int i = 0; i < 12; i++)
      if (k[i]) return code_tab[i];
    return 0;
  endfunction

  // Run-length view of debounce: accept after DEB equal key frames, release after DEB frames != num.
  task automatic model_frame(input int f, output bit pulse);
    pulse = 1'b0;
    if (m_num == 0) begin
      if (f == 0) m_run = 0;
      else if (m_run > 0 && f == m_cand) m_run++;
      else begin
        m_cand = f;
        m_run  = 1;
      end
      if (m_run == DEB) begin
        m_num = m_cand;
        m_run = 0;
        pulse = 1'b1;
      end
    end else begin
      if (f != m_num) m_run++;
      else m_run = 0;
      if (m_run == DEB) begin
        m_num = 0;
        m_run = 0;
      end
    end
  endtask

  task automatic run_frame(input logic [11:0] k);
    bit pulse;
    pressed = k;
    for (int c = 0; c < 3; c++) begin
      @(posedge slow_clk);
      #1;
      chk("key_col", {5'b0, key_col}, {5'b0, 3'b001 << ((c + 1) % 3)});
      if (c < 2) begin
        chk("key_press_idle", {7'b0, key_press}, 8'd0);
        chk("num_hold", {4'b0, num}, 8'(m_num));
      end else begin
        model_frame(frame_code(k), pulse);
        chk("num", {4'b0, num}, 8'(m_num));
        chk("key_press", {7'b0, key_press}, {7'b0, pulse});
      end
      if (key_press === 1'b1) pulses++;
    end
  endtask

  task automatic do_reset(input int ncyc);
    reset = 1'b1;
    repeat (ncyc) @(posedge slow_clk);
    #1;
    chk("rst_key_col", {5'b0, key_col}, 8'd1);
    chk("rst_num", {4'b0, num}, 8'd0);
    chk("rst_key_press", {7'b0, key_press}, 8'd0);
    reset = 1'b0;
    m_num = 0;
    m_run = 0;
  endtask

  initial begin
    int p0;
    int kind, len;
    logic [11:0] k;

    do_reset(3);
    run_frame('0);
    run_frame('0);

    // clean '5'
    p0 = pulses;
    repeat (4) run_frame(12'h010);
    chk("press5_num", {4'b0, num}, 8'd8);
    repeat (2) run_frame(12'h010);
    chk("press5_pulses", 8'(pulses - p0), 8'd1);
    repeat (3) run_frame('0);
    chk("rel5_mid", {4'b0, num}, 8'd8);
    run_frame('0);
    chk("rel5_num", {4'b0, num}, 8'd0);

    // bouncing '*'
    run_frame(12'h200); run_frame('0); run_frame(12'h200); run_frame('0);
    repeat (3) run_frame(12'h200);
    chk("bounce_pre", {4'b0, num}, 8'd0);
    run_frame(12'h200);
    chk("bounce_num", {4'b0, num}, 8'd1);
    repeat (4) run_frame('0);

    // '#' then directly '0'
    p0 = pulses;
    repeat (5) run_frame(12'h800);
    chk("k2k_hash", {4'b0, num}, 8'd2);
    repeat (4) run_frame(12'h400);
    chk("k2k_gap", {4'b0, num}, 8'd0);
    repeat (4) run_frame(12'h400);
    chk("k2k_zero", {4'b0, num}, 8'd3);
    chk("k2k_pulses", 8'(pulses - p0), 8'd2);
    repeat (4) run_frame('0);

    // reset in the middle of confirming '9'
    repeat (2) run_frame(12'h100);
    @(posedge slow_clk);
    #1;
    do_reset(2);
    repeat (3) run_frame(12'h100);
    chk("rst9_pre", {4'b0, num}, 8'd0);
    run_frame(12'h100);
    chk("rst9_num", {4'b0, num}, 8'd12);
    repeat (4) run_frame('0);

    // '1' and '3' together
    p0 = pulses;
    repeat (5) run_frame(12'h005);
`ifdef KEY_GHOST_REJECT_EN
    chk("multi_num", {4'b0, num}, 8'd0);
    chk("multi_pulses", 8'(pulses - p0), 8'd0);
`else
    chk("multi_num", {4'b0, num}, 8'd4);
    chk("multi_pulses", 8'(pulses - p0), 8'd1);
`endif
    repeat (4) run_frame('0);

    // randomized key activity
    for (int it = 0; it < 60; it++) begin
      kind = int'($urandom_range(0, 9));
      len  = int'($urandom_range(1, 6));
      k    = '0;
      if (kind >= 3) k[$urandom_range(0, 11)] = 1'b1;
      if (kind >= 8) k[$urandom_range(0, 11)] = 1'b1;
      repeat (len) run_frame(k);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
